// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state type, parity codes and bit-timing helper
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;
  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;
  function automatic int calc_divisor(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction
endpackage

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt: bit-period counter, restartable, flags the last clock of each bit
module uart_baud_cnt #(
  parameter int DIVISOR = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic bit_end
);
  localparam int CW = $clog2(DIVISOR);
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    bit_end = en && cnt_q == CW'(DIVISOR - 1);
    cnt_d = (clr || !en || bit_end) ? '0 : cnt_q + 1'b1;
  end
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
endmodule

// File: rtl/uart_tx.sv
// uart_tx: valid/ready byte in, LSB-first start/data/parity/stop frame out
module uart_tx #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 115200,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst_,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_serial,
  output logic       tx_busy,
  output logic       tx_done
);
  import uart_pkg::*;
  localparam int DIVISOR = calc_divisor(CLK_FREQ, BAUD_RATE);
  if (STOP_BITS < 1 || STOP_BITS > 2 || PARITY < 0 || PARITY > 2 || DIVISOR < 2) begin : g_bad_params
    $error("uart_tx: illegal STOP_BITS/PARITY/DIVISOR");
  end
  tx_state_t state_q, state_d;
  logic [7:0] shreg_q, shreg_d;
  logic [2:0] idx_q, idx_d;
  logic par_q, par_d, serial_q, serial_d, done_q, done_d;
  logic hs, bit_end;
  assign tx_ready  = state_q == IDLE && !rst_;
  assign tx_busy   = state_q != IDLE;
  assign tx_serial = serial_q;
  assign tx_done   = done_q;
  assign hs        = tx_valid && tx_ready;
  uart_baud_cnt #(.DIVISOR(DIVISOR)) u_baud (
    .clk(clk),
    .rst(rst_),
    .en(tx_busy),
    .clr(hs),
    .bit_end(bit_end)
  );
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    idx_d    = idx_q;
    par_d    = par_q;
    serial_d = serial_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: if (hs) begin
        state_d  = START;
        shreg_d  = tx_data;
        idx_d    = '0;
        par_d    = (PARITY == PAR_ODD) ? ~^tx_data : ^tx_data;
        serial_d = 1'b0;
      end
      START: if (bit_end) begin
        state_d  = DATA;
        serial_d = shreg_q[0];
      end
      DATA: if (bit_end) begin
        shreg_d  = shreg_q >> 1;
        idx_d    = idx_q + 1'b1;
        serial_d = shreg_q[1];
        if (idx_q == 3'd7) begin
          idx_d = '0;
          if (PARITY != PAR_NONE) begin
            state_d  = uart_pkg::PARITY;
            serial_d = par_q;
          end else begin
            state_d  = STOP;
            serial_d = 1'b1;
          end
        end
      end
      uart_pkg::PARITY: if (bit_end) begin
        state_d  = STOP;
        serial_d = 1'b1;
      end
      STOP: if (bit_end) begin
        idx_d = idx_q + 1'b1;
        if (idx_q == 3'(STOP_BITS - 1)) begin
          state_d = IDLE;
          idx_d   = '0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst_) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      idx_q    <= '0;
      par_q    <= 1'b0;
      serial_q <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      idx_q    <= idx_d;
      par_q    <= par_d;
      serial_q <= serial_d;
      done_q   <= done_d;
    end
  end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: three uart_tx configurations checked against a frame-level model
module tb_uart_tx;
  localparam int BAUD = 100_000;
  function automatic int div_of(int g);
    return g == 0 ? 16 : g == 1 ? 10 : 12;
  endfunction
  function automatic int par_of(int g);
    return g;
  endfunction
  function automatic int stop_of(int g);
    return g == 1 ? 2 : 1;
  endfunction
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] d [3];
  logic v [3];
  logic rdy [3];
  logic ser [3];
  logic busy [3];
  logic done [3];
  int n_cmp = 0;
  int n_bad = 0;
  longint cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    uart_tx #(
      .CLK_FREQ(div_of(g) * BAUD),
      .BAUD_RATE(BAUD),
      .PARITY(par_of(g)),
      .STOP_BITS(stop_of(g))
    ) dut (
      .clk(clk),
      .rst_(rst),
      .tx_data(d[g]),
      .tx_valid(v[g]),
      .tx_ready(rdy[g]),
      .tx_serial(ser[g]),
      .tx_busy(busy[g]),
      .tx_done(done[g])
    );
    a_idle_high: assert property (@(posedge clk) disable iff (rst) !busy[g] |-> ser[g]);
    a_done_pulse: assert property (@(posedge clk) disable iff (rst) done[g] |=> !done[g]);
    a_no_hs_busy: assert property (@(posedge clk) disable iff (rst) busy[g] |-> !rdy[g]);
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  function automatic bit par_bit(int p, logic [7:0] b);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    return p == 2 ? bit'((ones + 1) % 2) : bit'(ones % 2);
  endfunction
  task automatic send(input int g, input logic [7:0] b, input bit keep, output longint t_start);
    bit q[$];
    int n, ok, rd;
    q.push_back(1'b0);
    for (int i = 0; i < 8; i++) q.push_back(b[i]);
    if (par_of(g) != 0) q.push_back(par_bit(par_of(g), b));
    repeat (stop_of(g)) q.push_back(1'b1);
    d[g] = b;
    v[g] = 1'b1;
    n = 0;
    while (!rdy[g] && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ready_wait", 64'(n < 200), 1);
    @(posedge clk); #1;
    t_start = cyc;
    v[g] = keep;
    d[g] = 8'($urandom);
    chk("done_clear", done[g], 0);
    foreach (q[i]) begin
      ok = 0;
      rd = 0;
      for (int c = 0; c < div_of(g); c++) begin
        if (!keep && i == 4 && c == 0) begin
          v[g] = 1'b1;
          d[g] = 8'hFF;
        end
        if (!keep && i == 4 && c == 1) v[g] = 1'b0;
        ok += int'(ser[g] === q[i]);
        rd += int'(rdy[g]);
        @(posedge clk); #1;
      end
      chk($sformatf("g%0d byte %02h bit%0d clocks", g, b, i), ok, div_of(g));
      chk($sformatf("g%0d ready_low", g), rd, 0);
    end
    chk($sformatf("g%0d done", g), done[g], 1);
    chk($sformatf("g%0d ready_back", g), rdy[g], 1);
    chk($sformatf("g%0d idle_line", g), ser[g], 1);
    chk($sformatf("g%0d frame_len", g), cyc - t_start, div_of(g) * q.size());
    if (!keep) begin
      @(posedge clk); #1;
      chk("no_second_frame", busy[g], 0);
      chk("done_one_cycle", done[g], 0);
    end
  endtask
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    longint ts, prev;
    int bad_ser, bad_rdy, n_done;
    for (int g = 0; g < 3; g++) begin
      d[g] = '0;
      v[g] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int g = 0; g < 3; g++) begin
      chk("rst_serial", ser[g], 1);
      chk("rst_ready", rdy[g], 0);
      chk("rst_busy", busy[g], 0);
      chk("rst_done", done[g], 0);
    end
    rst = 1'b0;
    #1;
    for (int g = 0; g < 3; g++) chk("ready_after_rst", rdy[g], 1);
    send(0, 8'hA5, 0, ts);
    send(1, 8'h07, 0, ts);
    send(2, 8'h07, 0, ts);
    send(0, 8'h3C, 0, ts);
    for (int g = 0; g < 3; g++)
      for (int k = 0; k < 6; k++) send(g, 8'($urandom), 0, ts);
    prev = 0;
    for (int k = 0; k < 32; k++) begin
      send(0, 8'($urandom), k < 31, ts);
      if (k > 0) chk("b2b_spacing", ts - prev, div_of(0) * 10 + 1);
      prev = ts;
    end
    d[0] = 8'h81;
    v[0] = 1'b1;
    @(posedge clk); #1;
    v[0] = 1'b0;
    repeat (4 * div_of(0) + div_of(0) / 2) begin
      @(posedge clk); #1;
    end
    chk("pre_rst_bit3", ser[0], 0);
    chk("pre_rst_busy", busy[0], 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_serial", ser[0], 1);
    chk("abort_busy", busy[0], 0);
    chk("abort_done", done[0], 0);
    chk("abort_ready", rdy[0], 0);
    rst = 1'b0;
    #1;
    chk("abort_ready_back", rdy[0], 1);
    n_done = 0;
    bad_ser = 0;
    repeat (3 * div_of(0)) begin
      @(posedge clk); #1;
      n_done += int'(done[0]);
      bad_ser += int'(ser[0] !== 1'b1);
    end
    chk("abort_no_done", n_done, 0);
    chk("abort_line_high", bad_ser, 0);
    send(0, 8'h55, 0, ts);
    bad_ser = 0;
    bad_rdy = 0;
    n_done = 0;
    repeat (10000) begin
      @(posedge clk); #1;
      for (int g = 0; g < 3; g++) begin
        bad_ser += int'(ser[g] !== 1'b1);
        bad_rdy += int'(rdy[g] !== 1'b1);
        n_done += int'(done[g]);
      end
    end
    chk("idle_serial", bad_ser, 0);
    chk("idle_ready", bad_rdy, 0);
    chk("idle_done", n_done, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART transmitter: the transmit-side counterpart of uart_rx in the same UART block.
- Accepts one byte per valid/ready handshake.
- Serialises the byte LSB-first as start / data / optional parity / stop bits at BAUD_RATE.
- Drives the idle-high serial line that feeds uart_rx, or the off-chip TX pin.
- Shares CLK_FREQ/BAUD_RATE parameterisation with uart_rx, so a looped-back pair agrees on bit timing.

Parameters:
CLK_FREQ, 50_000_000, system clock frequency in Hz
BAUD_RATE, 115200, serial bit rate in bits/s
PARITY, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, number of stop bits; 1 or 2 are the only legal values
(derived) DIVISOR = CLK_FREQ/BAUD_RATE, integer division; clocks per bit

Ports:
clk  input  1  system clock, rising-edge
rst_  input  1  synchronous, active-high reset
tx_data  input  8  byte to send; sampled only on handshake
tx_valid  input  1  tx_data is valid
tx_ready  output  1  transmitter can accept a byte this cycle
tx_serial  output  1  serial line, idle high
tx_busy  output  1  a frame is in progress
tx_done  output  1  single-cycle pulse when a frame completes

Behaviour:
- Reset (rst_ = 1 at a posedge) forces the following on the next edge:
  - state = IDLE, tx_serial = 1, tx_ready = 0 while rst_ is high, tx_busy = 0, tx_done = 0.
  - Baud counter, bit index and shift register all cleared.
- Reset mid-frame: the frame is aborted immediately, the line returns high on the next edge, no tx_done is issued and the byte is discarded.
- tx_ready = 1 only in IDLE with rst_ low. tx_busy = !IDLE.
- Handshake: transfer occurs on a posedge with tx_valid && tx_ready.
  - tx_data is latched into the shift register on that edge; later changes to tx_data are ignored.
  - tx_valid asserted while tx_ready = 0 is ignored; nothing is queued.
- Latency: tx_serial drops to 0 (start bit) on the edge following the handshake edge.
- Bit timing: every bit, including start, parity and each stop bit, holds for exactly DIVISOR clocks.
  - The baud counter runs 0..DIVISOR-1 and resets at each bit boundary.
  - The counter is internal and restarts at frame start; it is not free-running.
- FSM:
  - IDLE: go to START on handshake.
  - START: drive 0 for one bit time, then go to DATA.
  - DATA: drive shreg[0] each bit, shifting right at each bit boundary, 8 bits with bit index 0..7. After bit 7 go to PARITY if PARITY != 0, else go to STOP.
  - PARITY: drive ^data for even parity or ~^data for odd parity, computed on the latched byte, then go to STOP.
  - STOP: drive 1 for STOP_BITS bit times, then go to IDLE.
- tx_done: high for one cycle, namely the first IDLE cycle after the final stop bit, coincident with tx_ready rising.
- Frame length: DIVISOR*(10 + (PARITY != 0) + (STOP_BITS - 1)) clocks. Minimum start-to-start spacing of back-to-back frames is that value + 1 clock, since the line idles high for one clock between frames.
- Handshake during the tx_done cycle is legal and starts the next frame.
- Illegal parameters (STOP_BITS not 1/2, PARITY > 2, DIVISOR < 2) are caught by an elaboration-time $error.

Decomposition:
- uart_pkg (shared with uart_rx and its SVA):
  - tx_state_t enum {IDLE, START, DATA, PARITY, STOP}
  - parity constants PAR_NONE/PAR_EVEN/PAR_ODD
  - function calc_divisor(clk_freq, baud)
- Sub-module uart_baud_cnt:
  - Counter with synchronous clear/restart, outputs bit_end when count == DIVISOR-1.
  - Reusable by uart_rx.
- Companion uart_tx_sva bound in the testbench:
  - line high in IDLE
  - tx_done one-cycle pulse
  - no handshake while busy

Test Plan:
- Reset then send 0xA5 with PARITY=0, STOP_BITS=1, DIVISOR=434 -> line sequence 0,1,0,1,0,0,1,0,1,1, each bit exactly 434 clocks; tx_done pulses 4340 clocks after the start bit begins.
- Loopback to uart_rx: 32 random bytes back-to-back, tx_valid held high -> uart_rx rx_data matches the scoreboard, rx_error = 0; start-to-start spacing = 4341 clocks.
- PARITY=1, send 0x07 -> parity bit = 1; PARITY=2, send 0x07 -> parity bit = 0; STOP_BITS=2 -> line high for 868 clocks before tx_ready rises.
- Change tx_data and pulse tx_valid mid-frame (0x3C in flight, 0xFF presented) -> frame still carries 0x3C, tx_ready stays 0, and no second frame starts unless tx_valid is held until tx_ready.
- Assert rst_ during data bit 3 of 0x81 -> tx_serial = 1 on the next edge, tx_busy = 0, no tx_done; a new 0x55 sent after reset is transmitted correctly.
- Idle with tx_valid = 0 for 10000 clocks -> tx_serial constantly 1, tx_ready = 1, tx_done never asserted.
